// File: rtl/nibble_serial_adder_if.sv
// Operand/result handshake bundle for the nibble-serial adder.
// The master drives operands and out_ready; the slave returns the result and status.
interface nibble_serial_adder_if #(
    parameter int WIDTH = 16
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] op_a;
    logic [WIDTH-1:0] op_b;
    logic             cin_in;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] sum;
    logic             cout;
    logic             busy;

    modport master (
        output in_valid, op_a, op_b, cin_in, out_ready,
        input  in_ready, out_valid, sum, cout, busy
    );

    modport slave (
        input  in_valid, op_a, op_b, cin_in, out_ready,
        output in_ready, out_valid, sum, cout, busy
    );
endinterface

// File: rtl/nibble_serial_adder.sv
// WIDTH-bit unsigned adder that reuses one 4-bit ripple-carry slice, one nibble per clock.
// Result and final carry are published only when the last nibble completes.
module nibble_serial_adder #(
    parameter int WIDTH = 16
) (
    input logic                  clk,
    input logic                  rst_n,
    nibble_serial_adder_if.slave bus
);
    localparam int NNIB = WIDTH / 4;
    localparam int CW   = (NNIB > 1) ? $clog2(NNIB) : 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state_q;
    logic [WIDTH-1:0] a_q;
    logic [WIDTH-1:0] b_q;
    logic [WIDTH-1:0] ws_q;
    logic             carry_q;
    logic [CW-1:0]    cnt_q;
    logic [WIDTH-1:0] sum_q;
    logic             cout_q;
    logic             out_valid_q;
    logic             in_ready_q;
    logic             busy_q;

    logic [CW+1:0]    sh_s;
    logic [3:0]       nib_a_s;
    logic [3:0]       nib_b_s;
    logic [4:0]       slice_s;
    logic [WIDTH-1:0] ws_d;
    logic             last_s;

    // 4-bit ripple-carry cell: returns {carry_out, sum[3:0]}
    function automatic logic [4:0] rca4(input logic [3:0] a, input logic [3:0] b, input logic ci);
        logic [4:0] r;
        logic       c;
        c = ci;
        for (int i = 0; i < 4; i++) begin
            r[i] = a[i] ^ b[i] ^ c;
            c    = (a[i] & b[i]) | (c & (a[i] ^ b[i]));
        end
        r[4] = c;
        return r;
    endfunction

    // Select the current nibble, run the slice and merge its result into the work sum
    always_comb begin
        sh_s    = {cnt_q, 2'b00};
        nib_a_s = 4'(a_q >> sh_s);
        nib_b_s = 4'(b_q >> sh_s);
        slice_s = rca4(nib_a_s, nib_b_s, carry_q);
        ws_d    = (ws_q & ~(WIDTH'(4'hF) << sh_s)) | (WIDTH'(slice_s[3:0]) << sh_s);
        last_s  = (cnt_q == CW'(NNIB - 1));
    end

    // Control FSM, nibble sequencing and registered handshake outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            a_q         <= '0;
            b_q         <= '0;
            ws_q        <= '0;
            carry_q     <= 1'b0;
            cnt_q       <= '0;
            sum_q       <= '0;
            cout_q      <= 1'b0;
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
            busy_q      <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (bus.in_valid && in_ready_q) begin
                        a_q        <= bus.op_a;
                        b_q        <= bus.op_b;
                        carry_q    <= bus.cin_in;
                        ws_q       <= '0;
                        cnt_q      <= '0;
                        in_ready_q <= 1'b0;
                        busy_q     <= 1'b1;
                        state_q    <= RUN;
                    end else begin
                        state_q <= IDLE;
                    end
                end
                RUN: begin
                    ws_q    <= ws_d;
                    carry_q <= slice_s[4];
                    if (last_s) begin
                        sum_q       <= ws_d;
                        cout_q      <= slice_s[4];
                        cnt_q       <= '0;
                        out_valid_q <= 1'b1;
                        state_q     <= DONE;
                    end else begin
                        cnt_q <= cnt_q + CW'(1);
                    end
                end
                DONE: begin
                    // sum/cout stay untouched here so they remain stable under backpressure
                    if (bus.out_ready) begin
                        out_valid_q <= 1'b0;
                        busy_q      <= 1'b0;
                        in_ready_q  <= 1'b1;
                        state_q     <= IDLE;
                    end else begin
                        state_q <= DONE;
                    end
                end
                default: begin
                    out_valid_q <= 1'b0;
                    busy_q      <= 1'b0;
                    in_ready_q  <= 1'b1;
                    state_q     <= IDLE;
                end
            endcase
        end
    end

    assign bus.in_ready  = in_ready_q;
    assign bus.out_valid = out_valid_q;
    assign bus.sum       = sum_q;
    assign bus.cout      = cout_q;
    assign bus.busy      = busy_q;
endmodule

// File: tb/tb_nibble_serial_adder.sv
// Bench for nibble_serial_adder: directed cases plus randomized operations
// checked against plain (WIDTH+1)-bit arithmetic, for WIDTH=16 and WIDTH=4.
module tb_nibble_serial_adder;
    logic clk = 1'b0;
    logic rst_n;
    int   checks = 0;
    int   errors = 0;

    nibble_serial_adder_if #(.WIDTH(16)) b16 ();
    nibble_serial_adder_if #(.WIDTH(4))  b4 ();

    nibble_serial_adder #(.WIDTH(16)) dut16 (.clk(clk), .rst_n(rst_n), .bus(b16.slave));
    nibble_serial_adder #(.WIDTH(4))  dut4  (.clk(clk), .rst_n(rst_n), .bus(b4.slave));

    always #5 clk = ~clk;

    // Offer one operation, wait for the result, optionally stall, then complete the handshake.
    task automatic run16(input logic [15:0] a, input logic [15:0] b, input logic ci, input int stall,
                         output logic [15:0] s, output logic c, output int lat, output bit stable);
        int guard;
        @(negedge clk);
        b16.op_a = a; b16.op_b = b; b16.cin_in = ci; b16.in_valid = 1'b1; b16.out_ready = 1'b0;
        guard = 0;
        while (!b16.in_ready && guard < 50) begin
            @(negedge clk);
            guard++;
        end
        @(posedge clk); #1;
        b16.in_valid = 1'b0;
        b16.op_a = 16'($urandom);
        b16.op_b = 16'($urandom);
        lat = 0;
        while (!b16.out_valid && lat < 20) begin
            @(posedge clk); #1;
            lat++;
        end
        s = b16.sum; c = b16.cout; stable = 1'b1;
        repeat (stall) begin
            @(posedge clk); #1;
            if (b16.sum !== s || b16.cout !== c || b16.out_valid !== 1'b1) stable = 1'b0;
        end
        b16.out_ready = 1'b1;
        @(posedge clk); #1;
        b16.out_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        b16.in_valid = 1'b0; b16.op_a = 16'h0000; b16.op_b = 16'h0000; b16.cin_in = 1'b0; b16.out_ready = 1'b0;
        b4.in_valid = 1'b0; b4.op_a = 4'h0; b4.op_b = 4'h0; b4.cin_in = 1'b0; b4.out_ready = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk); rst_n = 1'b1;
        @(posedge clk); #1;
        checks++; if (b16.sum !== 16'h0000) begin errors++; $display("FAIL reset_sum: got %h expected 0000", b16.sum); end
        checks++; if (b16.cout !== 1'b0) begin errors++; $display("FAIL reset_cout: got %b expected 0", b16.cout); end
        checks++; if (b16.out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid: got %b expected 0", b16.out_valid); end
        checks++; if (b16.busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", b16.busy); end
        checks++; if (b16.in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready: got %b expected 1", b16.in_ready); end
        checks++; if (b4.in_ready !== 1'b1 || b4.out_valid !== 1'b0) begin errors++; $display("FAIL reset_w4: got rdy=%b vld=%b expected rdy=1 vld=0", b4.in_ready, b4.out_valid); end
    endtask

    task automatic test_directed();
        logic [15:0] s; logic c; int lat; bit st;
        run16(16'h1234, 16'h4321, 1'b0, 0, s, c, lat, st);
        checks++; if (lat !== 4) begin errors++; $display("FAIL basic_latency: got %0d expected 4", lat); end
        checks++; if (s !== 16'h5555) begin errors++; $display("FAIL basic_sum: got %h expected 5555", s); end
        checks++; if (c !== 1'b0) begin errors++; $display("FAIL basic_cout: got %b expected 0", c); end
        checks++; if (b16.out_valid !== 1'b0 || b16.in_ready !== 1'b1 || b16.busy !== 1'b0) begin
            errors++; $display("FAIL basic_idle_after: got vld=%b rdy=%b busy=%b expected 0 1 0", b16.out_valid, b16.in_ready, b16.busy); end
        checks++; if (b16.sum !== 16'h5555) begin errors++; $display("FAIL basic_sum_held: got %h expected 5555", b16.sum); end
        run16(16'hFFFF, 16'h0000, 1'b1, 0, s, c, lat, st);
        checks++; if (s !== 16'h0000 || c !== 1'b1) begin errors++; $display("FAIL ripple_all: got %b_%h expected 1_0000", c, s); end
        checks++; if (lat !== 4) begin errors++; $display("FAIL ripple_latency: got %0d expected 4", lat); end
    endtask

    task automatic test_backpressure();
        int lat;
        @(negedge clk);
        b16.op_a = 16'h00FF; b16.op_b = 16'h0001; b16.cin_in = 1'b0; b16.in_valid = 1'b1; b16.out_ready = 1'b0;
        @(posedge clk); #1;
        checks++; if (b16.busy !== 1'b1) begin errors++; $display("FAIL bp_accept1: got busy=%b expected 1", b16.busy); end
        b16.op_a = 16'h0002; b16.op_b = 16'h0003;
        lat = 0;
        while (!b16.out_valid && lat < 20) begin @(posedge clk); #1; lat++; end
        checks++; if (lat !== 4 || b16.sum !== 16'h0100) begin errors++; $display("FAIL bp_first: got lat=%0d sum=%h expected lat=4 sum=0100", lat, b16.sum); end
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            checks++;
            if (b16.sum !== 16'h0100 || b16.in_ready !== 1'b0 || b16.out_valid !== 1'b1) begin
                errors++; $display("FAIL bp_stall%0d: got sum=%h rdy=%b vld=%b expected 0100 0 1", i, b16.sum, b16.in_ready, b16.out_valid); end
        end
        b16.out_ready = 1'b1;
        @(posedge clk); #1;
        checks++; if (b16.in_ready !== 1'b1 || b16.out_valid !== 1'b0 || b16.sum !== 16'h0100) begin
            errors++; $display("FAIL bp_idle: got rdy=%b vld=%b sum=%h expected 1 0 0100", b16.in_ready, b16.out_valid, b16.sum); end
        @(posedge clk); #1;
        checks++; if (b16.busy !== 1'b1 || b16.in_ready !== 1'b0) begin
            errors++; $display("FAIL bp_accept2: got busy=%b rdy=%b expected 1 0", b16.busy, b16.in_ready); end
        b16.in_valid = 1'b0;
        lat = 0;
        while (!b16.out_valid && lat < 20) begin @(posedge clk); #1; lat++; end
        checks++; if (lat !== 4 || b16.sum !== 16'h0005 || b16.cout !== 1'b0) begin
            errors++; $display("FAIL bp_second: got lat=%0d sum=%h cout=%b expected 4 0005 0", lat, b16.sum, b16.cout); end
        @(posedge clk); #1;
        b16.out_ready = 1'b0;
    endtask

    task automatic test_reset_mid_run();
        logic [15:0] s; logic c; int lat; bit st;
        @(negedge clk);
        b16.op_a = 16'hFFFF; b16.op_b = 16'h0001; b16.cin_in = 1'b0; b16.in_valid = 1'b1;
        @(posedge clk); #1;
        b16.in_valid = 1'b0;
        repeat (2) @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        checks++; if (b16.sum !== 16'h0000 || b16.cout !== 1'b0) begin errors++; $display("FAIL rst_mid_result: got %b_%h expected 0_0000", b16.cout, b16.sum); end
        checks++; if (b16.busy !== 1'b0 || b16.out_valid !== 1'b0 || b16.in_ready !== 1'b1) begin
            errors++; $display("FAIL rst_mid_state: got busy=%b vld=%b rdy=%b expected 0 0 1", b16.busy, b16.out_valid, b16.in_ready); end
        @(negedge clk); rst_n = 1'b1;
        run16(16'h8000, 16'h8000, 1'b0, 0, s, c, lat, st);
        checks++; if (s !== 16'h0000 || c !== 1'b1 || lat !== 4) begin
            errors++; $display("FAIL rst_after_op: got %b_%h lat=%0d expected 1_0000 lat=4", c, s, lat); end
    endtask

    task automatic test_random16();
        logic [15:0] a, b, s; logic ci, c; int lat, stall; bit st; logic [16:0] exp_v;
        for (int n = 0; n < 25; n++) begin
            a = 16'($urandom); b = 16'($urandom); ci = 1'($urandom); stall = $urandom_range(0, 3);
            if (n == 0) begin a = 16'hFFFF; b = 16'hFFFF; ci = 1'b1; end
            exp_v = 17'(a) + 17'(b) + 17'(ci);
            run16(a, b, ci, stall, s, c, lat, st);
            checks++;
            if ({c, s} !== exp_v || lat !== 4 || st !== 1'b1) begin
                errors++; $display("FAIL rand16_%0d: got %b_%h lat=%0d stable=%b expected %b_%h lat=4 stable=1",
                                   n, c, s, lat, st, exp_v[16], exp_v[15:0]); end
        end
    endtask

    task automatic test_width4();
        logic [3:0] a, b; logic ci; int lat; logic [4:0] exp_v;
        for (int n = 0; n < 10; n++) begin
            a = 4'($urandom); b = 4'($urandom); ci = 1'($urandom);
            if (n == 0) begin a = 4'h9; b = 4'h8; ci = 1'b1; end
            exp_v = 5'(a) + 5'(b) + 5'(ci);
            @(negedge clk);
            b4.op_a = a; b4.op_b = b; b4.cin_in = ci; b4.in_valid = 1'b1;
            @(posedge clk); #1;
            b4.in_valid = 1'b0;
            lat = 0;
            while (!b4.out_valid && lat < 20) begin @(posedge clk); #1; lat++; end
            checks++;
            if ({b4.cout, b4.sum} !== exp_v || lat !== 1) begin
                errors++; $display("FAIL w4_op%0d: got %b_%h lat=%0d expected %b_%h lat=1", n, b4.cout, b4.sum, lat, exp_v[4], exp_v[3:0]); end
            b4.out_ready = 1'b1;
            @(posedge clk); #1;
            b4.out_ready = 1'b0;
            checks++;
            if (b4.out_valid !== 1'b0 || b4.in_ready !== 1'b1) begin
                errors++; $display("FAIL w4_idle%0d: got vld=%b rdy=%b expected 0 1", n, b4.out_valid, b4.in_ready); end
        end
    endtask

    initial begin
        test_reset();
        test_directed();
        test_backpressure();
        test_reset_mid_run();
        test_random16();
        test_width4();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
